// File: rtl/squ_bash_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : squ_bash_loader_if
// Description : Avalon-MM read-master and bias-FIFO write-port bundle for the
//               squeeze bias loader. The master modport is the loader side.
// Revision    : 1.0 - initial release
// ============================================================================
interface squ_bash_loader_if #(
  parameter int ADDR_W = 32
);
  // Avalon-MM pipelined read master
  logic [ADDR_W-1:0] m_address_o;
  logic              m_read_o;
  logic              m_waitrequest_i;
  logic [63:0]       m_readdata_i;
  logic              m_readdatavalid_i;

  // Bias FIFO write side
  logic              fifo_squ_bash_clr_o;
  logic [63:0]       fifo_squ_bash_wr_data_o;
  logic              fifo_squ_bash_wr_en_o;
  logic [6:0]        fifo_squ_bash_data_count_i;

  modport master (
    output m_address_o,
    output m_read_o,
    input  m_waitrequest_i,
    input  m_readdata_i,
    input  m_readdatavalid_i,
    output fifo_squ_bash_clr_o,
    output fifo_squ_bash_wr_data_o,
    output fifo_squ_bash_wr_en_o,
    input  fifo_squ_bash_data_count_i
  );

  modport slave (
    input  m_address_o,
    input  m_read_o,
    output m_waitrequest_i,
    output m_readdata_i,
    output m_readdatavalid_i,
    input  fifo_squ_bash_clr_o,
    input  fifo_squ_bash_wr_data_o,
    input  fifo_squ_bash_wr_en_o,
    output fifo_squ_bash_data_count_i
  );
endinterface
`default_nettype wire

// File: rtl/squ_bash_loader.sv
`default_nettype none
// ============================================================================
// Module      : squ_bash_loader
// Description : Fetches the packed 8-bit squeeze biases (eight per 64-bit word)
//               over an Avalon-MM pipelined read master and pushes each word
//               unmodified into the bias FIFO, throttled by FIFO fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module squ_bash_loader #(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_LIMIT      = 120
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [9:0]        no_of_squ_kernals_i,
  input  logic [ADDR_W-1:0] bash_base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  squ_bash_loader_if.master bus
);

  localparam int                OUT_W        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]  c_max_out    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [7:0]        c_fifo_limit = 8'(FIFO_LIMIT);
  localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(7);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_clr1  = 3'd1;
  localparam logic [2:0] c_st_clr2  = 3'd2;
  localparam logic [2:0] c_st_issue = 3'd3;
  localparam logic [2:0] c_st_drain = 3'd4;
  localparam logic [2:0] c_st_done  = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [10:0]       r_total;
  logic [ADDR_W-1:0] r_base;
  logic [10:0]       r_issued;
  logic [10:0]       r_received;
  logic [OUT_W-1:0]  r_out;
  logic              r_hold;
  logic              r_done;
  logic              r_wr_en;
  logic [63:0]       r_wr_data;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_rx_ok;
  logic              w_dec;
  logic [7:0]        w_fill;
  logic              w_can_issue;
  logic              w_read;
  logic              w_clr;
  logic              w_busy;
  logic [10:0]       w_total;

  // Start is honoured only when no job is in flight.
  assign w_start_ok = start_i && ((r_state == c_st_idle) || (r_state == c_st_done));
  // Eight kernels share one word, so K>>3 is the index of the last word.
  assign w_total    = {1'b0, no_of_squ_kernals_i >> 3} + 11'd1;
  assign w_accept   = w_read && !bus.m_waitrequest_i;
  // Data returning outside an active fetch, or past the job length, is dropped.
  assign w_rx_ok    = bus.m_readdatavalid_i
                      && ((r_state == c_st_issue) || (r_state == c_st_drain))
                      && (r_received < r_total);
  assign w_dec      = w_rx_ok && (r_out != '0);
  // Reads in flight will land in the FIFO later, so they count against the fill level.
  assign w_fill      = 8'(bus.fifo_squ_bash_data_count_i) + 8'(r_out);
  assign w_can_issue = (r_issued < r_total) && (r_out < c_max_out) && (w_fill < c_fifo_limit);

  assign bus.m_address_o             = r_base + ADDR_W'({r_issued, 3'b000});
  assign bus.m_read_o                = w_read;
  assign bus.fifo_squ_bash_clr_o     = w_clr;
  assign bus.fifo_squ_bash_wr_en_o   = r_wr_en;
  assign bus.fifo_squ_bash_wr_data_o = r_wr_data;
  assign busy_o                      = w_busy;
  assign done_o                      = r_done;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= c_st_idle;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (w_start_ok) w_next = c_st_clr1;
      c_st_clr1:  w_next = c_st_clr2;
      c_st_clr2:  w_next = c_st_issue;
      c_st_issue: if (w_accept && ((r_issued + 11'd1) == r_total)) w_next = c_st_drain;
      c_st_drain: if (r_received == r_total) w_next = c_st_done;
      c_st_done:  if (w_start_ok) w_next = c_st_clr1;
      default:    w_next = c_st_idle;
    endcase
  end

  // Outputs decoded from state; a stalled read stays asserted until accepted.
  always_comb begin
    w_busy = 1'b0;
    w_clr  = 1'b0;
    w_read = 1'b0;
    case (r_state)
      c_st_clr1:  begin w_busy = 1'b1; w_clr = 1'b1; end
      c_st_clr2:  w_busy = 1'b1;
      c_st_issue: begin w_busy = 1'b1; w_read = r_hold || w_can_issue; end
      c_st_drain: w_busy = 1'b1;
      default:    ;
    endcase
  end

  // Job configuration, captured on an accepted start only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_total <= '0;
      r_base  <= '0;
    end else if (w_start_ok) begin
      r_total <= w_total;
      r_base  <= bash_base_addr_i & c_align_mask;
    end
  end

  // Issue / receive / outstanding counters and the stall hold flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_issued   <= '0;
      r_received <= '0;
      r_out      <= '0;
      r_hold     <= 1'b0;
    end else if (r_state == c_st_clr1) begin
      r_issued   <= '0;
      r_received <= '0;
      r_out      <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_hold <= w_read && bus.m_waitrequest_i;
      if (w_accept) r_issued   <= r_issued + 11'd1;
      if (w_rx_ok)  r_received <= r_received + 11'd1;
      case ({w_accept, w_dec})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
    end
  end

  // FIFO write port: returned data registered one cycle, passed through as-is.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_rx_ok;
      if (w_rx_ok) r_wr_data <= bus.m_readdata_i;
    end
  end

  // Done pulse on the single cycle the FSM enters DONE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_done <= 1'b0;
    else          r_done <= (w_next == c_st_done) && (r_state != c_st_done);
  end

endmodule
`default_nettype wire

// File: tb/tb_squ_bash_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_squ_bash_loader
// Description : Directed self-checking bench for squ_bash_loader with an
//               Avalon read-memory model of variable latency and stall control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_squ_bash_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  k_in;
  logic [31:0] base_in;
  logic        busy, done;
  logic [6:0]  fifo_cnt;
  logic        inj_valid;

  squ_bash_loader_if #(.ADDR_W(32)) bus ();

  squ_bash_loader #(.ADDR_W(32), .MAX_OUTSTANDING(8), .FIFO_LIMIT(120)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start),
    .no_of_squ_kernals_i (k_in),
    .bash_base_addr_i    (base_in),
    .busy_o              (busy),
    .done_o              (done),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  // Memory model: fixed latency pipeline plus an optional 5-cycle stall.
  int          lat       = 2;
  int          stall_at  = -1;
  int          m_acc     = 0;
  int          stall_cnt = 0;
  logic        vpipe [16] = '{default: 1'b0};
  logic [31:0] apipe [16] = '{default: 32'h0};
  logic        mdl_valid = 1'b0;
  logic [63:0] mdl_data  = 64'h0;

  assign bus.m_waitrequest_i            = (m_acc == stall_at) && (stall_cnt < 5);
  assign bus.m_readdatavalid_i          = mdl_valid | inj_valid;
  assign bus.m_readdata_i               = mdl_data;
  assign bus.fifo_squ_bash_data_count_i = fifo_cnt;

  always @(posedge clk) begin
    vpipe[0] <= bus.m_read_o && !bus.m_waitrequest_i;
    apipe[0] <= bus.m_address_o;
    for (int i = 1; i < 16; i++) begin
      vpipe[i] <= vpipe[i-1];
      apipe[i] <= apipe[i-1];
    end
    mdl_valid <= vpipe[lat-2];
    mdl_data  <= mem_word(apipe[lat-2]);
    if (bus.m_read_o && !bus.m_waitrequest_i) m_acc <= m_acc + 1;
    if (bus.m_read_o && bus.m_waitrequest_i)  stall_cnt <= stall_cnt + 1;
  end

  // Monitor, sampled on the falling edge.
  logic [31:0] acc_q [$];
  logic [63:0] wr_q  [$];
  int          n_clr = 0, n_done = 0, n_stall = 0, stab_err = 0, thr_err = 0;
  int          out_mon = 0, max_out = 0;
  bit          win = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    if (!rst_n) out_mon = 0;
    if (bus.m_read_o && bus.m_waitrequest_i) begin
      n_stall++;
      if (prev_stall && (bus.m_address_o != prev_addr)) stab_err++;
    end
    if (prev_stall && !bus.m_read_o) stab_err++;
    prev_stall = bus.m_read_o && bus.m_waitrequest_i;
    prev_addr  = bus.m_address_o;
    if (bus.m_read_o && ((int'(fifo_cnt) + out_mon) >= 120)) thr_err++;
    if (!win) max_out = 0;
    else if (out_mon > max_out) max_out = out_mon;
    if (bus.m_read_o && !bus.m_waitrequest_i) begin
      acc_q.push_back(bus.m_address_o);
      out_mon++;
    end
    if (mdl_valid && (out_mon > 0)) out_mon--;
    if (bus.fifo_squ_bash_wr_en_o) wr_q.push_back(bus.fifo_squ_bash_wr_data_o);
    if (bus.fifo_squ_bash_clr_o) n_clr++;
    if (done) n_done++;
  end

  int n_assert = 0, n_fail = 0;
  int rd0, wr0, clr0, done0, st0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [9:0] k, input logic [31:0] b);
    rd0 = acc_q.size(); wr0 = wr_q.size(); clr0 = n_clr; done0 = n_done; st0 = n_stall;
    @(posedge clk); #2;
    k_in = k; base_in = b; start = 1'b1;
    @(negedge clk);
    chk("busy_before_clear", busy, 1'b0);
    @(posedge clk); #2;
    start = 1'b0; k_in = 10'h3FF; base_in = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("clr_first", bus.fifo_squ_bash_clr_o, 1'b1);
    chk("busy_in_clear", busy, 1'b1);
    @(negedge clk);
    chk("clr_second", bus.fifo_squ_bash_clr_o, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while ((n_done == done0) && (c < budget)) begin
      @(negedge clk);
      c++;
    end
    chk("done_in_time", (c < budget), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_job(input logic [31:0] b, input int n);
    chk("clr_pulses", n_clr - clr0, 1);
    chk("done_pulses", n_done - done0, 1);
    chk("busy_after_done", busy, 1'b0);
    chk("read_count", acc_q.size() - rd0, n);
    chk("write_count", wr_q.size() - wr0, n);
    for (int i = 0; i < n; i++) begin
      if ((rd0 + i) < acc_q.size()) chk("read_addr", acc_q[rd0+i], b + 32'(8*i));
      if ((wr0 + i) < wr_q.size())  chk("wr_data", wr_q[wr0+i], mem_word(b + 32'(8*i)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int w0, r0, cl0;
    rst_n = 1'b0; start = 1'b0; k_in = '0; base_in = '0; fifo_cnt = '0; inj_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_read",  bus.m_read_o, 1'b0);
    chk("rst_addr",  bus.m_address_o, 32'h0);
    chk("rst_clr",   bus.fifo_squ_bash_clr_o, 1'b0);
    chk("rst_wr_en", bus.fifo_squ_bash_wr_en_o, 1'b0);
    chk("rst_wdata", bus.fifo_squ_bash_wr_data_o, 64'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // K=15 -> two words at 0x1000/0x1008, 2-cycle latency
    start_job(10'd15, 32'h0000_1000);
    wait_done(200);
    chk("k15_addr0", acc_q[rd0], 32'h0000_1000);
    chk("k15_addr1", acc_q[rd0+1], 32'h0000_1008);
    chk("k15_data0", wr_q[wr0], 64'hA5A5_4A5A_FFFF_EFFF);
    check_job(32'h0000_1000, 2);

    // Stray readdatavalid while in DONE must not write the FIFO
    w0 = wr_q.size();
    @(posedge clk); #2 inj_valid = 1'b1;
    @(posedge clk); #2 inj_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_valid_dropped", wr_q.size() - w0, 0);

    // K=0 with misaligned base -> one read at 0x2000
    start_job(10'd0, 32'h0000_2007);
    wait_done(200);
    check_job(32'h0000_2000, 1);

    // Five-cycle waitrequest on the second read of a four-word job
    stall_at = m_acc + 1;
    start_job(10'd31, 32'h0000_4000);
    wait_done(300);
    chk("stall_cycles", n_stall - st0, 5);
    chk("stall_stable", stab_err, 0);
    check_job(32'h0000_4000, 4);

    // Start during ISSUE is ignored; job of 8 words completes unchanged
    start_job(10'd63, 32'h0000_3000);
    c = 0;
    while ((acc_q.size() < rd0 + 2) && (c < 100)) begin @(negedge clk); c++; end
    chk("ign_reads_started", (c < 100), 1'b1);
    @(posedge clk); #2 k_in = 10'd7; base_in = 32'h0000_7000; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("ign_busy", busy, 1'b1);
    wait_done(300);
    check_job(32'h0000_3000, 8);

    // A new start after DONE runs the new job with a fresh clear
    start_job(10'd7, 32'h0000_5000);
    wait_done(200);
    check_job(32'h0000_5000, 1);

    // FIFO count held at 115: outstanding capped at 5, then released to 8
    lat = 10; fifo_cnt = 7'd115;
    start_job(10'd1023, 32'h0000_8000);
    win = 1'b1;
    repeat (40) @(negedge clk);
    chk("thr_max_out_held", max_out, 5);
    chk("thr_partial", (acc_q.size() - rd0) < 128, 1'b1);
    fifo_cnt = 7'd0; win = 1'b0;
    @(negedge clk); win = 1'b1;
    wait_done(3000);
    chk("thr_max_out_free", max_out, 8);
    win = 1'b0;
    chk("thr_violations", thr_err, 0);
    check_job(32'h0000_8000, 128);

    // Asynchronous reset mid-ISSUE with reads in flight
    start_job(10'd1023, 32'h0000_9000);
    c = 0;
    while ((acc_q.size() < rd0 + 4) && (c < 100)) begin @(negedge clk); c++; end
    chk("rst_reads_started", (c < 100), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  busy, 1'b0);
    chk("arst_read",  bus.m_read_o, 1'b0);
    chk("arst_addr",  bus.m_address_o, 32'h0);
    chk("arst_wr_en", bus.fifo_squ_bash_wr_en_o, 1'b0);
    chk("arst_wdata", bus.fifo_squ_bash_wr_data_o, 64'h0);
    chk("arst_clr",   bus.fifo_squ_bash_clr_o, 1'b0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    w0 = wr_q.size(); r0 = acc_q.size(); cl0 = n_clr;
    repeat (20) @(negedge clk);
    chk("post_rst_no_writes", wr_q.size() - w0, 0);
    chk("post_rst_no_reads",  acc_q.size() - r0, 0);
    chk("post_rst_no_clr",    n_clr - cl0, 0);
    chk("post_rst_idle",      busy, 1'b0);

    // K=8 boundary after reset -> two words
    lat = 2;
    start_job(10'd8, 32'h0000_A000);
    wait_done(200);
    check_job(32'h0000_A000, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/squ_bash_loader.md
Name: squ_bash_loader

Overview:
Fetch engine feeding the squeeze bias ("bash") FIFO. On start it clears the FIFO, then reads the packed 8-bit biases for all squeeze kernels from external memory over an Avalon-MM pipelined read master. It pushes each returned 64-bit word unmodified into the FIFO write port, throttled by the FIFO fill count. It is the write-side counterpart of the bias controller, which drains the FIFO into its bias RAM.

Parameters:
ADDR_W, 32, Avalon byte-address width.
MAX_OUTSTANDING, 8, maximum accepted reads awaiting readdatavalid.
FIFO_LIMIT, 120, issue threshold for (fifo_squ_bash_data_count_i + outstanding); FIFO depth is 128 words.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle job start; accepted only in IDLE or DONE
no_of_squ_kernals_i  in  10  number of squeeze kernels - 1 (K)
bash_base_addr_i  in  ADDR_W  byte address of bias block; bits [2:0] ignored
busy_o  out  1  high from accepted start until the last word is written
done_o  out  1  one-cycle pulse when the last word is written to the FIFO
m_address_o  out  ADDR_W  Avalon read address, 8-byte aligned
m_read_o  out  1  Avalon read request
m_waitrequest_i  in  1  Avalon stall
m_readdata_i  in  64  Avalon read data
m_readdatavalid_i  in  1  Avalon read data valid
fifo_squ_bash_clr_o  out  1  FIFO asynchronous clear
fifo_squ_bash_wr_data_o  out  64  FIFO write data
fifo_squ_bash_wr_en_o  out  1  FIFO write enable
fifo_squ_bash_data_count_i  in  7  FIFO write-side used words

Behaviour:
- Reset (async, rst_n_i low): state IDLE; all outputs 0; all counters 0.
- Config capture on accepted start_i:
  - latch K and the base address with [2:0] forced to 0;
  - total_words = (K >> 3) + 1, 11-bit width (K=0 gives 1, K=7 gives 1, K=8 gives 2, K=1023 gives 128).
- Byte packing: kernel n's bias is byte (n mod 8) of word (n >> 3), bits [8*(n mod 8)+7 : 8*(n mod 8)], so the 8-bit FIFO read side sees LSB first. Data passes through unmodified. Unused top bytes of the last word are written anyway.
- FSM:
  - IDLE: on start_i go to CLEAR; busy_o goes high the next cycle.
  - CLEAR: 2 cycles. fifo_squ_bash_clr_o is high in the first cycle only. Issue counter, receive counter and outstanding counter are zeroed. Then go to ISSUE.
  - ISSUE: m_read_o high when issued < total_words AND outstanding < MAX_OUTSTANDING AND (data_count + outstanding) < FIFO_LIMIT.
    - A read is accepted when m_read_o and not m_waitrequest_i.
    - While m_waitrequest_i is high, m_read_o and m_address_o must hold stable. Once asserted, m_read_o is not withdrawn until accepted.
    - m_address_o = base + 8*issued.
    - On acceptance, issued is incremented. When issued reaches total_words, go to DRAIN.
  - DRAIN: m_read_o low. Wait until received == total_words, then go to DONE.
  - DONE: done_o pulses for the cycle of entry; busy_o is low. start_i re-enters CLEAR.
- Outstanding counter: +1 on accept, -1 on readdatavalid, unchanged when both occur in the same cycle. It never exceeds MAX_OUTSTANDING and never underflows.
- Write path:
  - fifo_squ_bash_wr_en_o is m_readdatavalid_i registered: 1-cycle latency.
  - wr_data is m_readdata_i registered on valid and held otherwise.
  - received is incremented on each write.
- Readdatavalid in IDLE, CLEAR or DONE, or beyond total_words, is a protocol error. It is dropped: no FIFO write.
- start_i while busy (CLEAR, ISSUE, DRAIN) is ignored; latched config is unchanged.
- The FIFO never overflows: the throttle covers count-lag plus in-flight reads.

Test Plan:
- K=15, base 0x1000, no wait states, 2-cycle read latency -> clr pulse; reads at 0x1000 and 0x1008; 2 FIFO writes with data matching m_readdata_i; done_o pulses once; busy_o falls.
- K=0, base 0x2007 -> exactly one read at 0x2000; one FIFO write; done.
- K=1023, FIFO count held at 115 -> m_read_o high only while count + outstanding < 120. After release, all 128 reads issue at 0x..000 to 0x..3F8 in order. Outstanding never exceeds 8.
- m_waitrequest_i high for 5 cycles on the 2nd read -> address and m_read_o stable throughout; no duplicate or skipped address.
- start_i pulsed during ISSUE with a different K -> ignored; original word count completes. A start after DONE runs the new job with a new clr pulse.
- rst_n_i low mid-ISSUE with reads outstanding -> all outputs 0 asynchronously. After release: IDLE, no FIFO writes until the next start.
